// File: rtl/fft8_ctrl_if.sv
// Streaming handshake bundle for fft8_ctrl.
// Sample stream in, one FFT bin per beat out.
interface fft8_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_re;
  logic [7:0] out_im;
  logic [2:0] out_idx;
  logic       out_last;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_re,
    output out_im,
    output out_idx,
    output out_last
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_re,
    input  out_im,
    input  out_idx,
    input  out_last
  );
endinterface

// File: rtl/fft8_ctrl.sv
// Frame sequencer around a combinational 8-point FFT.
// Define FFT8_CTRL_BITREV_EN to drain bins in bit-reversed order.
module fft8_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fft8_ctrl_if.slave  bus,
  output logic [63:0] fft_a,
  input  logic [63:0] fft_xr,
  input  logic [63:0] fft_xi,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam logic [3:0] SETTLE_INIT =
    4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  settle_cnt;
  logic [63:0] samp;
  logic [63:0] res_re;
  logic [63:0] res_im;
  logic [2:0]  bin;
  logic        in_acc;
  logic        out_acc;

  assign in_acc  = bus.in_valid
                && (state == LOAD);
  assign out_acc = bus.out_ready
                && (state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:
        if (in_acc && wr_ptr == 3'd7)
          state_nxt = SETTLE;
      SETTLE:
        if (settle_cnt == 4'd0)
          state_nxt = CAPTURE;
      CAPTURE:
        state_nxt = DRAIN;
      DRAIN:
        if (out_acc && rd_ptr == 3'd7)
          state_nxt = LOAD;
      default:
        state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      settle_cnt <= '0;
      samp       <= '0;
      res_re     <= '0;
      res_im     <= '0;
      frame_cnt  <= '0;
    end else begin
      if (in_acc) begin
        samp[{wr_ptr, 3'b000} +: 8]
          <= bus.in_data;
        wr_ptr <= wr_ptr + 3'd1;
        if (wr_ptr == 3'd7)
          settle_cnt <= SETTLE_INIT;
      end
      if (state == SETTLE
          && settle_cnt != 4'd0)
        settle_cnt <= settle_cnt - 4'd1;
      // results are frozen here; later fft_x* changes are ignored
      if (state == CAPTURE) begin
        res_re <= fft_xr;
        res_im <= fft_xi;
        rd_ptr <= '0;
      end
      if (out_acc) begin
        rd_ptr <= rd_ptr + 3'd1;
        if (rd_ptr == 3'd7)
          frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

`ifdef FFT8_CTRL_BITREV_EN
  assign bin = {rd_ptr[0], rd_ptr[1], rd_ptr[2]};
`else
  assign bin = rd_ptr;
`endif

  assign fft_a         = samp;
  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign busy          = (state != LOAD);
  assign bus.out_re    = res_re[{bin, 3'b000} +: 8];
  assign bus.out_im    = res_im[{bin, 3'b000} +: 8];
  assign bus.out_idx   = bin;
  assign bus.out_last  = (state == DRAIN)
                      && (rd_ptr == 3'd7);

endmodule

// File: tb/tb_fft8_ctrl.sv
// Randomized bench for fft8_ctrl with an FFT stub:
// xr = a, xi = ~a, plus a forcing hook on xr.
module tb_fft8_ctrl;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft8_ctrl_if bus ();
  logic [63:0] fft_a;
  logic [63:0] fft_xr;
  logic [63:0] fft_xi;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic        xr_force = 1'b0;

  assign fft_xr = xr_force ? '1 : fft_a;
  assign fft_xi = ~fft_a;

  fft8_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fft_a     (fft_a),
    .fft_xr    (fft_xr),
    .fft_xi    (fft_xi),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

`ifdef FFT8_CTRL_BITREV_EN
  int order_tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int order_tbl[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  task automatic send_frame(
    input logic [7:0] s[8],
    input bit gaps
  );
    int i = 0;
    int guard = 0;
    while (i < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.in_valid = gaps ?
        ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data = bus.in_valid ?
        s[i] : 8'($urandom);
      if (bus.in_valid && bus.in_ready) i++;
    end
    checks++;
    if (i != 8) begin
      errors++;
      $display("FAIL send_timeout accepted=%0d required=8", i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // mode 0: ready high, 1: pattern 1,0,0, 2: random
  task automatic drain_frame(
    input logic [7:0] s[8],
    input int mode,
    input bit iso,
    input int rst_at
  );
    logic [63:0] pk;
    logic [7:0]  e_re, e_im, p_re, p_im;
    logic [2:0]  e_idx, p_idx;
    logic        e_last, p_last, r;
    int m = 0;
    int j = 0;
    int guard = 0;
    int pat = 0;
    bit stall = 1'b0;
    for (int k = 0; k < 8; k++)
      pk[8*k +: 8] = s[k];
    checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b1
        || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL settle_entry in_ready=%b busy=%b out_valid=%b required 0,1,0",
        bus.in_ready, busy, bus.out_valid);
    end
    while (bus.out_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      m++;
      guard++;
    end
    checks++;
    if (m != S + 2) begin
      errors++;
      $display("FAIL first_valid_edge got=%0d required=%0d", m, S + 2);
    end
    guard = 0;
    while (j < 8 && guard < 400) begin
      if (rst_at == j) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0
            || bus.in_ready !== 1'b1
            || frame_cnt !== 8'd0 || fft_a !== 64'd0
            || bus.out_last !== 1'b0
            || bus.out_re !== 8'd0) begin
          errors++;
          $display("FAIL reset_mid_drain ov=%b busy=%b ir=%b fc=%0d a=%h re=%h required 0,0,1,0,0,0",
            bus.out_valid, busy, bus.in_ready,
            frame_cnt, fft_a, bus.out_re);
        end
        model_cnt = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        xr_force = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (iso) xr_force = 1'b1;
      checks++;
      if (bus.out_valid !== 1'b1 || busy !== 1'b1
          || bus.in_ready !== 1'b0
          || fft_a !== pk) begin
        errors++;
        $display("FAIL drain_status beat=%0d ov=%b busy=%b ir=%b a=%h required 1,1,0,%h",
          j, bus.out_valid, busy, bus.in_ready, fft_a, pk);
      end
      e_idx  = 3'(order_tbl[j]);
      e_re   = s[order_tbl[j]];
      e_im   = ~s[order_tbl[j]];
      e_last = (j == 7);
      checks++;
      if ({bus.out_re, bus.out_im,
           bus.out_idx, bus.out_last}
          !== {e_re, e_im, e_idx, e_last}) begin
        errors++;
        $display("FAIL beat%0d re=%h im=%h idx=%0d last=%b required %h %h %0d %b",
          j, bus.out_re, bus.out_im, bus.out_idx,
          bus.out_last, e_re, e_im, e_idx, e_last);
      end
      if (stall) begin
        checks++;
        if ({bus.out_re, bus.out_im,
             bus.out_idx, bus.out_last}
            !== {p_re, p_im, p_idx, p_last}) begin
          errors++;
          $display("FAIL stall_hold beat=%0d re=%h idx=%0d required %h %0d",
            j, bus.out_re, bus.out_idx, p_re, p_idx);
        end
      end
      case (mode)
        0: r = 1'b1;
        1: r = (pat % 3) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      pat++;
      bus.out_ready = r;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = 8'($urandom);
      stall  = !r;
      p_re   = bus.out_re;
      p_im   = bus.out_im;
      p_idx  = bus.out_idx;
      p_last = bus.out_last;
      if (r) j++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    xr_force = 1'b0;
    checks++;
    if (j != 8) begin
      errors++;
      $display("FAIL drain_timeout beats=%0d required=8", j);
    end
    model_cnt = (model_cnt + 1) % 256;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
        || busy !== 1'b0
        || frame_cnt !== 8'(model_cnt)) begin
      errors++;
      $display("FAIL frame_end ir=%b ov=%b busy=%b fc=%0d required 1,0,0,%0d",
        bus.in_ready, bus.out_valid, busy,
        frame_cnt, model_cnt);
    end
  endtask

  task automatic fill_seq(
    output logic [7:0] s[8],
    input logic [7:0] base
  );
    for (int k = 0; k < 8; k++)
      s[k] = base + 8'(k);
  endtask

  task automatic fill_rand(output logic [7:0] s[8]);
    for (int k = 0; k < 8; k++)
      s[k] = 8'($urandom);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5a;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
        || busy !== 1'b0 || frame_cnt !== 8'd0
        || fft_a !== 64'd0 || bus.out_last !== 1'b0
        || bus.out_re !== 8'd0 || bus.out_im !== 8'd0
        || bus.out_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_values ir=%b ov=%b busy=%b fc=%0d a=%h required 1,0,0,0,0",
        bus.in_ready, bus.out_valid, busy,
        frame_cnt, fft_a);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fft_a !== 64'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release a=%h ir=%b required 0,1",
        fft_a, bus.in_ready);
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] s[8];
    fill_seq(s, 8'h10);
    bus.out_ready = 1'b1;
    send_frame(s, 1'b0);
    drain_frame(s, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure;
    logic [7:0] s[8];
    fill_rand(s);
    send_frame(s, 1'b1);
    drain_frame(s, 1, 1'b0, -1);
  endtask

  task automatic test_capture_isolation;
    logic [7:0] s[8];
    fill_seq(s, 8'h10);
    send_frame(s, 1'b0);
    drain_frame(s, 0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_drain;
    logic [7:0] s[8];
    fill_rand(s);
    send_frame(s, 1'b0);
    drain_frame(s, 0, 1'b0, 3);
    fill_seq(s, 8'h20);
    send_frame(s, 1'b0);
    drain_frame(s, 0, 1'b0, -1);
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL cnt_after_reset fc=%0d required=1", frame_cnt);
    end
  endtask

  task automatic test_frames_256;
    logic [7:0] s[8];
    for (int f = 0; f < 256; f++) begin
      fill_rand(s);
      send_frame(s, 1'($urandom_range(0, 1)));
      drain_frame(s, 2, 1'b0, -1);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    test_reset;
    test_single_frame;
    test_backpressure;
    test_capture_isolation;
    test_reset_mid_drain;
    test_frames_256;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
